// File: rtl/mccu_pkg.sv
// Types and default widths shared between the MCCU, its register wrapper and
// the budget controller that sits around it.
package mccu_pkg;

  localparam int MCCU_DATA_WIDTH = 32;
  localparam int MCCU_N_CORES    = 2;
  localparam int MCCU_CNT_WIDTH  = 16;

  typedef logic [MCCU_DATA_WIDTH-1:0] quota_t;
  typedef logic [MCCU_CNT_WIDTH-1:0]  ovr_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/mccu_core_budget.sv
// Per-core exhaustion tracking: one-shot-per-period flag, sticky interrupt
// and saturating count of periods in which the budget ran out.
module mccu_core_budget
  import mccu_pkg::*;
#(
  parameter int CNT_WIDTH = MCCU_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 run_i,
  input  logic                 reload_i,
  input  logic                 irq_i,
  input  logic                 irq_clear_i,
  output logic                 irq_o,
  output logic [CNT_WIDTH-1:0] overrun_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 exh_q, exh_d;
  logic                 irq_q, irq_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit;

  // A reload opens a new period, so an interrupt in that same cycle counts
  // against the new budget even if the old period was already exhausted.
  always_comb begin
    hit   = run_i && irq_i && (reload_i || !exh_q);
    exh_d = exh_q;
    if (reload_i) exh_d = 1'b0;
    if (hit)      exh_d = 1'b1;
    irq_d = irq_q && !irq_clear_i;
    if (hit)      irq_d = 1'b1;
    cnt_d = cnt_q;
    if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  // Per-core state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exh_q <= 1'b0;
      irq_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      exh_q <= exh_d;
      irq_q <= irq_d;
      cnt_q <= cnt_d;
    end
  end

  assign irq_o         = irq_q;
  assign overrun_cnt_o = cnt_q;

endmodule

// File: rtl/mccu_budget_ctrl.sv
// Periodic budget controller around the MCCU: reloads per-core quotas at each
// period start and turns the MCCU level interrupts into sticky interrupts.
//
// state | meaning
// IDLE  | regulation off, MCCU disabled, quotas passed through untouched
// LOAD  | one cycle: budgets pushed to MCCU, period counter armed
// RUN   | MCCU enabled, period counts down, reload when it reaches zero
module mccu_budget_ctrl
  import mccu_pkg::*;
#(
  parameter int DATA_WIDTH = MCCU_DATA_WIDTH,
  parameter int N_CORES    = MCCU_N_CORES,
  parameter int CNT_WIDTH  = MCCU_CNT_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                enable_i,
  input  logic [DATA_WIDTH-1:0]               period_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]  budget_i,
  input  logic [N_CORES-1:0]                  irq_clear_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]  mccu_quota_i,
  input  logic [N_CORES-1:0]                  mccu_irq_i,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0]  mccu_quota_o,
  output logic                                mccu_enable_o,
  output logic [N_CORES-1:0]                  irq_o,
  output logic [N_CORES-1:0][CNT_WIDTH-1:0]   overrun_cnt_o,
  output logic [DATA_WIDTH-1:0]               period_cnt_o,
  output logic                                reload_o
);

  localparam logic [DATA_WIDTH-1:0] PERIOD_ONE = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                  mccu_enable_q, mccu_enable_d;
  logic                  run;
  logic                  reload;
  logic                  period_zero;

  assign period_zero = (period_i == '0);
  assign run         = (state_q == RUN);
  assign reload      = (state_q == LOAD) || (run && !period_zero && (period_cnt_q == '0));

  // Next state and period countdown; a new period_i is only sampled on reload.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    case (state_q)
      IDLE: if (enable_i) state_d = LOAD;
      LOAD: begin
        state_d      = RUN;
        period_cnt_d = period_zero ? '0 : period_i - PERIOD_ONE;
      end
      RUN: begin
        if (!period_zero) begin
          period_cnt_d = (period_cnt_q == '0) ? period_i - PERIOD_ONE
                                              : period_cnt_q - PERIOD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) state_d = IDLE;
    mccu_enable_d = (state_d == RUN);
  end

  // FSM, period counter and MCCU enable registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      mccu_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      mccu_enable_q <= mccu_enable_d;
    end
  end

  // MCCU reloads whenever its quota input differs from what it holds, so echo
  // its own value back except on a reload cycle.
  always_comb begin
    mccu_quota_o = mccu_quota_i;
    if (reload) mccu_quota_o = budget_i;
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    mccu_core_budget #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .run_i         (run),
      .reload_i      (reload),
      .irq_i         (mccu_irq_i[g]),
      .irq_clear_i   (irq_clear_i[g]),
      .irq_o         (irq_o[g]),
      .overrun_cnt_o (overrun_cnt_o[g])
    );
  end

  assign mccu_enable_o = mccu_enable_q;
  assign period_cnt_o  = period_cnt_q;
  assign reload_o      = reload;

endmodule

// File: tb/tb_mccu_budget_ctrl.sv
// Directed bench for mccu_budget_ctrl; a second instance with 4-bit counters
// shares the stimulus to observe saturation.
module tb_mccu_budget_ctrl;

  localparam int DW = 32;
  localparam int NC = 2;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic                   enable_i;
  logic [DW-1:0]          period_i;
  logic [NC-1:0][DW-1:0]  budget_i;
  logic [NC-1:0]          irq_clear_i;
  logic [NC-1:0][DW-1:0]  mccu_quota_i;
  logic [NC-1:0]          mccu_irq_i;

  logic [NC-1:0][DW-1:0]  mccu_quota_o;
  logic                   mccu_enable_o;
  logic [NC-1:0]          irq_o;
  logic [NC-1:0][15:0]    overrun_cnt_o;
  logic [DW-1:0]          period_cnt_o;
  logic                   reload_o;

  logic [NC-1:0][DW-1:0]  q4_o;
  logic                   en4_o;
  logic [NC-1:0]          irq4_o;
  logic [NC-1:0][3:0]     cnt4_o;
  logic [DW-1:0]          pc4_o;
  logic                   rl4_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  mccu_budget_ctrl #(.DATA_WIDTH(DW), .N_CORES(NC), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .period_i(period_i),
    .budget_i(budget_i), .irq_clear_i(irq_clear_i), .mccu_quota_i(mccu_quota_i),
    .mccu_irq_i(mccu_irq_i), .mccu_quota_o(mccu_quota_o), .mccu_enable_o(mccu_enable_o),
    .irq_o(irq_o), .overrun_cnt_o(overrun_cnt_o), .period_cnt_o(period_cnt_o),
    .reload_o(reload_o)
  );

  mccu_budget_ctrl #(.DATA_WIDTH(DW), .N_CORES(NC), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .period_i(period_i),
    .budget_i(budget_i), .irq_clear_i(irq_clear_i), .mccu_quota_i(mccu_quota_i),
    .mccu_irq_i(mccu_irq_i), .mccu_quota_o(q4_o), .mccu_enable_o(en4_o),
    .irq_o(irq4_o), .overrun_cnt_o(cnt4_o), .period_cnt_o(pc4_o),
    .reload_o(rl4_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_reload(input int max_cyc, input string tag);
    int n = 0;
    while (reload_o !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, reload_o, 1'b1);
  endtask

  initial begin
    int pulses;
    rstn_i       = 1'b0;
    enable_i     = 1'b0;
    period_i     = 10;
    budget_i[0]  = 100;
    budget_i[1]  = 200;
    irq_clear_i  = '0;
    mccu_quota_i = '0;
    mccu_irq_i   = '0;

    #12;
    chk("rst_enable", mccu_enable_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_cnt0", overrun_cnt_o[0], 0);
    chk("rst_cnt1", overrun_cnt_o[1], 0);
    chk("rst_pcnt", period_cnt_o, 0);
    chk("rst_reload", reload_o, 0);
    chk("rst_quota_pass", mccu_quota_o[0], 0);
    chk("rst4_all", {q4_o[0][3:0], en4_o, irq4_o, cnt4_o, pc4_o[3:0], rl4_o}, 0);
    rstn_i = 1'b1;

    tick();
    enable_i = 1'b1;
    tick();
    chk("load_reload", reload_o, 1);
    chk("load_quota0", mccu_quota_o[0], 100);
    chk("load_quota1", mccu_quota_o[1], 200);
    chk("load_enable", mccu_enable_o, 0);
    mccu_quota_i[0] = 100;
    mccu_quota_i[1] = 200;
    tick();
    chk("run_enable", mccu_enable_o, 1);
    chk("run_pcnt", period_cnt_o, 9);
    chk("run_noreload", reload_o, 0);
    mccu_quota_i[0] = 57;
    #1;
    chk("pass_57", mccu_quota_o[0], 57);

    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("period_reload", reload_o, (k == 9));
      if (k == 5) chk("pass_57_mid", mccu_quota_o[0], 57);
    end
    chk("reload_quota", mccu_quota_o[0], 100);
    chk("reload_pcnt", period_cnt_o, 0);
    tick();
    chk("new_period_pcnt", period_cnt_o, 9);

    // three consecutive interrupts in one period count once
    mccu_irq_i[0] = 1'b1;
    tick();
    chk("irq_latency", irq_o[0], 1);
    chk("cnt_first", overrun_cnt_o[0], 1);
    tick();
    tick();
    mccu_irq_i[0] = 1'b0;
    chk("cnt_no_recount", overrun_cnt_o[0], 1);

    // interrupt coincident with reload counts for the new period
    wait_reload(12, "reload_p2");
    mccu_irq_i[0] = 1'b1;
    tick();
    mccu_irq_i[0] = 1'b0;
    chk("cnt_two_periods", overrun_cnt_o[0], 2);
    chk("irq_still_set", irq_o[0], 1);

    // new exhaustion and clear in the same cycle: set wins
    wait_reload(12, "reload_p3");
    mccu_irq_i[0]  = 1'b1;
    irq_clear_i[0] = 1'b1;
    tick();
    mccu_irq_i[0]  = 1'b0;
    chk("set_beats_clear", irq_o[0], 1);
    chk("cnt_p3", overrun_cnt_o[0], 3);
    tick();
    irq_clear_i[0] = 1'b0;
    chk("clear_alone", irq_o[0], 0);
    chk("clear_keeps_cnt", overrun_cnt_o[0], 3);
    chk("cnt4_p3", cnt4_o[0], 3);

    for (int p = 0; p < 17; p++) begin
      wait_reload(12, "reload_sat");
      mccu_irq_i[0] = 1'b1;
      tick();
      mccu_irq_i[0] = 1'b0;
    end
    chk("cnt_20", overrun_cnt_o[0], 20);
    chk("cnt4_sat", cnt4_o[0], 15);
    chk("cnt1_idle_core", overrun_cnt_o[1], 0);
    chk("irq1_idle_core", irq_o[1], 0);

    irq_clear_i[0] = 1'b1;
    tick();
    irq_clear_i[0] = 1'b0;
    chk("clear2", irq_o[0], 0);

    // disabled: interrupts ignored, counters hold
    enable_i = 1'b0;
    tick();
    chk("disable_enable", mccu_enable_o, 0);
    mccu_irq_i[0] = 1'b1;
    tick();
    tick();
    chk("idle_ignore_cnt", overrun_cnt_o[0], 20);
    chk("idle_ignore_irq", irq_o[0], 0);
    enable_i = 1'b1;
    tick();
    chk("reenable_load", reload_o, 1);
    chk("reenable_quota", mccu_quota_o[0], 100);
    chk("reenable_en0", mccu_enable_o, 0);
    tick();
    chk("load_ignore_cnt", overrun_cnt_o[0], 20);
    chk("load_ignore_irq", irq_o[0], 0);
    chk("reenable_run", mccu_enable_o, 1);
    tick();
    mccu_irq_i[0] = 1'b0;
    chk("run_counts_again", overrun_cnt_o[0], 21);
    chk("run_irq_again", irq_o[0], 1);
    chk("cnt4_held_sat", cnt4_o[0], 15);

    // asynchronous reset mid-period
    #3 rstn_i = 1'b0;
    #1;
    chk("arst_enable", mccu_enable_o, 0);
    chk("arst_irq", irq_o, 0);
    chk("arst_cnt0", overrun_cnt_o[0], 0);
    chk("arst_cnt4", cnt4_o[0], 0);
    chk("arst_pcnt", period_cnt_o, 0);
    chk("arst_reload", reload_o, 0);
    period_i = 0;
    #2 rstn_i = 1'b1;

    // one-shot mode
    tick();
    chk("os_load_reload", reload_o, 1);
    chk("os_load_pcnt", period_cnt_o, 0);
    tick();
    chk("os_run_enable", mccu_enable_o, 1);
    chk("os_run_noreload", reload_o, 0);
    pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (reload_o === 1'b1) pulses++;
    end
    chk("os_no_reloads", pulses, 0);
    chk("os_pcnt_zero", period_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
